// File: rtl/trap_seq_pkg.sv
// Shared types for the trap sequencer: data width, FSM states, event kinds,
// request-vector bit positions and RISC-V mcause exception codes.
package trap_seq_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        S_RESET    = 3'd0,
        S_IDLE     = 3'd1,
        S_DRAIN    = 3'd2,
        S_COMMIT   = 3'd3,
        S_REDIRECT = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        EV_EXC    = 2'd0,
        EV_MRET   = 2'd1,
        EV_FENCEI = 2'd2,
        EV_IRQ    = 2'd3
    } event_e;

    // Request vector layout; a lower index wins arbitration.
    localparam int REQ_W      = 4;
    localparam int REQ_EXC    = 0;
    localparam int REQ_MRET   = 1;
    localparam int REQ_FENCEI = 2;
    localparam int REQ_IRQ    = 3;

    typedef enum logic [3:0] {
        MCAUSE_INSN_MISALIGNED  = 4'd0,
        MCAUSE_INSN_ACCESS      = 4'd1,
        MCAUSE_ILLEGAL_INSN     = 4'd2,
        MCAUSE_BREAKPOINT       = 4'd3,
        MCAUSE_LOAD_MISALIGNED  = 4'd4,
        MCAUSE_LOAD_ACCESS      = 4'd5,
        MCAUSE_STORE_MISALIGNED = 4'd6,
        MCAUSE_STORE_ACCESS     = 4'd7,
        MCAUSE_ECALL_U          = 4'd8,
        MCAUSE_ECALL_S          = 4'd9,
        MCAUSE_ECALL_M          = 4'd11
    } mcause_e;

    function automatic event_e grant_to_event(input logic [REQ_W-1:0] grant);
        event_e ev;
        case (grant)
            4'b0001: ev = EV_EXC;
            4'b0010: ev = EV_MRET;
            4'b0100: ev = EV_FENCEI;
            4'b1000: ev = EV_IRQ;
            default: ev = EV_EXC;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/trap_seq_if.sv
// Request/response bundle between the trap sequencer and its requesters,
// the CSR unit and the fetch stage.
interface trap_seq_if;
    import trap_seq_pkg::*;

    logic            exc_req;
    logic [3:0]      exc_code;
    logic [XLEN-1:0] exc_pc;
    logic            mret_req;
    logic            fencei_req;
    logic [XLEN-1:0] fencei_pc;
    logic            irq_req;
    logic [XLEN-1:0] int_pc;
    logic            mem_busy;
    logic [XLEN-1:0] csr_new_pc;

    logic            stall;
    logic            req_ack;
    logic            take_exc;
    logic            take_irq;
    logic            mret_instr;
    logic [3:0]      exc_code_o;
    logic [XLEN-1:0] trap_val;
    logic [XLEN-1:0] curr_pc;
    logic [XLEN-1:0] next_pc;
    logic            jump_vld;
    logic [XLEN-1:0] jump_pc;
    logic            clear_pipeline;
    logic            drain_timeout;

    modport master (
        output exc_req, exc_code, exc_pc, mret_req, fencei_req, fencei_pc,
               irq_req, int_pc, mem_busy, csr_new_pc,
        input  stall, req_ack, take_exc, take_irq, mret_instr, exc_code_o,
               trap_val, curr_pc, next_pc, jump_vld, jump_pc, clear_pipeline,
               drain_timeout
    );

    modport slave (
        input  exc_req, exc_code, exc_pc, mret_req, fencei_req, fencei_pc,
               irq_req, int_pc, mem_busy, csr_new_pc,
        output stall, req_ack, take_exc, take_irq, mret_instr, exc_code_o,
               trap_val, curr_pc, next_pc, jump_vld, jump_pc, clear_pipeline,
               drain_timeout
    );

endinterface

// File: rtl/trap_prio.sv
// Fixed-priority arbiter for trap-sequencer events: exc > mret > fencei > irq.
// Purely combinational; the grant is one-hot or all-zero.
module trap_prio
    import trap_seq_pkg::*;
(
    input  logic [REQ_W-1:0] req_i,
    output logic [REQ_W-1:0] grant_o
);

    // Priority chain selecting the single winning request
    always_comb begin
        grant_o = {REQ_W{1'b0}};
        if (req_i[REQ_EXC]) begin
            grant_o[REQ_EXC] = 1'b1;
        end else if (req_i[REQ_MRET]) begin
            grant_o[REQ_MRET] = 1'b1;
        end else if (req_i[REQ_FENCEI]) begin
            grant_o[REQ_FENCEI] = 1'b1;
        end else if (req_i[REQ_IRQ]) begin
            grant_o[REQ_IRQ] = 1'b1;
        end else begin
            grant_o = {REQ_W{1'b0}};
        end
    end

endmodule

// File: rtl/trap_seq.sv
// Trap sequencer: arbitrates exceptions, MRET, FENCE.I and interrupts, drains
// memory, strobes the CSR unit and redirects fetch. Interrupt handling is
// compiled in only when TRAP_SEQ_IRQ_EN is defined.
module trap_seq
    import trap_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] START_ADDR = 32'h0000_0200,
    parameter int unsigned     DRAIN_MAX  = 15
)(
    input  logic       clk,
    input  logic       rst,
    trap_seq_if.slave  bus
);

    localparam int CNT_W = ($clog2(DRAIN_MAX + 1) > 4) ? $clog2(DRAIN_MAX + 1) : 4;

    state_e            state_q, state_d;
    logic              boot_q;
    event_e            ev_q, ev_d;
    logic [3:0]        code_q, code_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   ipc_q, ipc_d;
    logic [XLEN-1:0]   tgt_q, tgt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              irq_s;
    logic [XLEN-1:0]   int_pc_s;
    logic [REQ_W-1:0]  req_vec_s;
    logic [REQ_W-1:0]  grant_s;
    logic              any_req_s;
    logic              drain_to_s;

    logic              req_ack_s;
    logic              take_exc_s;
    logic              take_irq_s;
    logic              mret_instr_s;
    logic [3:0]        exc_code_s;
    logic [XLEN-1:0]   trap_val_s;
    logic [XLEN-1:0]   curr_pc_s;
    logic [XLEN-1:0]   next_pc_s;
    logic              jump_vld_s;
    logic [XLEN-1:0]   jump_pc_s;
    logic              clear_s;

`ifdef TRAP_SEQ_IRQ_EN
    assign irq_s    = bus.irq_req;
    assign int_pc_s = bus.int_pc;
`else
    assign irq_s    = 1'b0;
    assign int_pc_s = {XLEN{1'b0}};
`endif

    assign req_vec_s = {irq_s, bus.fencei_req, bus.mret_req, bus.exc_req};
    assign any_req_s = |req_vec_s;

    trap_prio u_prio (
        .req_i   (req_vec_s),
        .grant_o (grant_s)
    );

    // Next-state, event capture, drain counting and target selection
    always_comb begin
        state_d    = state_q;
        ev_d       = ev_q;
        code_d     = code_q;
        pc_d       = pc_q;
        ipc_d      = ipc_q;
        tgt_d      = tgt_q;
        cnt_d      = cnt_q;
        drain_to_s = 1'b0;
        case (state_q)
            S_RESET: begin
                if (boot_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESET;
                end
            end
            S_IDLE: begin
                if (any_req_s) begin
                    ev_d   = grant_to_event(grant_s);
                    code_d = grant_s[REQ_EXC] ? bus.exc_code : 4'd0;
                    if (grant_s[REQ_EXC]) begin
                        pc_d = bus.exc_pc;
                    end else if (grant_s[REQ_FENCEI]) begin
                        pc_d = bus.fencei_pc;
                    end else begin
                        pc_d = {XLEN{1'b0}};
                    end
                    ipc_d   = int_pc_s;
                    // Counter reads 1 in the first DRAIN cycle, so DRAIN never exceeds DRAIN_MAX cycles.
                    cnt_d   = CNT_W'(1);
                    state_d = bus.mem_busy ? S_DRAIN : S_COMMIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if ((ev_q == EV_IRQ) && !irq_s) begin
                    state_d = S_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (!bus.mem_busy) begin
                    state_d = S_COMMIT;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (32'(cnt_q) >= DRAIN_MAX) begin
                    state_d    = S_COMMIT;
                    cnt_d      = {CNT_W{1'b0}};
                    drain_to_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_COMMIT: begin
                if (ev_q == EV_FENCEI) begin
                    tgt_d = pc_q + XLEN'(4);
                end else begin
                    tgt_d = bus.csr_new_pc;
                end
                state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    // State register; boot flag marks the single post-release RESET cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RESET;
            boot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            boot_q  <= 1'b1;
        end
    end

    // Latched event fields, drain counter and redirect target
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ev_q   <= EV_EXC;
            code_q <= 4'd0;
            pc_q   <= {XLEN{1'b0}};
            ipc_q  <= {XLEN{1'b0}};
            tgt_q  <= {XLEN{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            ev_q   <= ev_d;
            code_q <= code_d;
            pc_q   <= pc_d;
            ipc_q  <= ipc_d;
            tgt_q  <= tgt_d;
            cnt_q  <= cnt_d;
        end
    end

    // Output decode from registered state and latched fields
    always_comb begin
        req_ack_s    = 1'b0;
        take_exc_s   = 1'b0;
        take_irq_s   = 1'b0;
        mret_instr_s = 1'b0;
        exc_code_s   = 4'd0;
        trap_val_s   = {XLEN{1'b0}};
        curr_pc_s    = {XLEN{1'b0}};
        next_pc_s    = {XLEN{1'b0}};
        jump_vld_s   = 1'b0;
        jump_pc_s    = {XLEN{1'b0}};
        clear_s      = 1'b0;
        case (state_q)
            S_RESET: begin
                if (boot_q) begin
                    jump_vld_s = 1'b1;
                    jump_pc_s  = START_ADDR;
                end else begin
                    jump_vld_s = 1'b0;
                end
            end
            S_COMMIT: begin
                req_ack_s    = (ev_q != EV_IRQ);
                take_exc_s   = (ev_q == EV_EXC);
                take_irq_s   = (ev_q == EV_IRQ);
                mret_instr_s = (ev_q == EV_MRET);
                exc_code_s   = code_q;
                trap_val_s   = pc_q;
                curr_pc_s    = pc_q;
                next_pc_s    = ipc_q;
            end
            S_REDIRECT: begin
                jump_vld_s = 1'b1;
                jump_pc_s  = tgt_q;
                clear_s    = (ev_q == EV_EXC) || (ev_q == EV_IRQ);
            end
            default: begin
                jump_vld_s = 1'b0;
            end
        endcase
    end

    assign bus.stall          = (state_q != S_IDLE) || any_req_s;
    assign bus.req_ack        = req_ack_s;
    assign bus.take_exc       = take_exc_s;
    assign bus.take_irq       = take_irq_s;
    assign bus.mret_instr     = mret_instr_s;
    assign bus.exc_code_o     = exc_code_s;
    assign bus.trap_val       = trap_val_s;
    assign bus.curr_pc        = curr_pc_s;
    assign bus.next_pc        = next_pc_s;
    assign bus.jump_vld       = jump_vld_s;
    assign bus.jump_pc        = jump_pc_s;
    assign bus.clear_pipeline = clear_s;
    assign bus.drain_timeout  = drain_to_s;

endmodule

// File: tb/tb_trap_seq.sv
// Directed self-checking bench for trap_seq; expectations follow the
// TRAP_SEQ_IRQ_EN setting of the build.
module tb_trap_seq;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    trap_seq_if bus ();

    trap_seq #(
        .START_ADDR (32'h0000_0200),
        .DRAIN_MAX  (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.exc_req = 1'b0; bus.exc_code = 4'd0; bus.exc_pc = 32'd0;
        bus.mret_req = 1'b0; bus.fencei_req = 1'b0; bus.fencei_pc = 32'd0;
        bus.irq_req = 1'b0; bus.int_pc = 32'd0; bus.mem_busy = 1'b0;
        bus.csr_new_pc = 32'd0;

        // reset held
        tick(); tick(); tick();
        chk("rst_stall", 32'(bus.stall), 32'd1);
        chk("rst_jvld", 32'(bus.jump_vld), 32'd0);
        chk("rst_jpc", bus.jump_pc, 32'd0);
        chk("rst_ack", 32'(bus.req_ack), 32'd0);
        rst = 1'b1;
        tick();
        chk("boot_jvld", 32'(bus.jump_vld), 32'd1);
        chk("boot_jpc", bus.jump_pc, 32'h0000_0200);
        tick();
        chk("idle_jvld", 32'(bus.jump_vld), 32'd0);
        chk("idle_stall", 32'(bus.stall), 32'd0);

        // exception, no drain
        bus.exc_req = 1'b1; bus.exc_code = 4'd2; bus.exc_pc = 32'h0000_1000;
        bus.csr_new_pc = 32'h0000_0080;
        #1;
        chk("exc_stall_comb", 32'(bus.stall), 32'd1);
        chk("exc_no_early", 32'(bus.take_exc), 32'd0);
        tick();
        chk("exc_take", 32'(bus.take_exc), 32'd1);
        chk("exc_ack", 32'(bus.req_ack), 32'd1);
        chk("exc_code", 32'(bus.exc_code_o), 32'd2);
        chk("exc_tval", bus.trap_val, 32'h0000_1000);
        chk("exc_cpc", bus.curr_pc, 32'h0000_1000);
        chk("exc_commit_jvld", 32'(bus.jump_vld), 32'd0);
        bus.exc_req = 1'b0;
        tick();
        chk("exc_redir_jvld", 32'(bus.jump_vld), 32'd1);
        chk("exc_redir_jpc", bus.jump_pc, 32'h0000_0080);
        chk("exc_clear", 32'(bus.clear_pipeline), 32'd1);
        chk("exc_redir_take", 32'(bus.take_exc), 32'd0);
        tick();
        chk("exc_back_idle", 32'(bus.stall), 32'd0);

        // fence.i with three busy cycles and PC wrap
        bus.fencei_req = 1'b1; bus.fencei_pc = 32'hFFFF_FFFC; bus.mem_busy = 1'b1;
        bus.csr_new_pc = 32'h0000_1234;
        tick();
        chk("fi_drain1_ack", 32'(bus.req_ack), 32'd0);
        chk("fi_drain1_stall", 32'(bus.stall), 32'd1);
        tick();
        chk("fi_drain2_ack", 32'(bus.req_ack), 32'd0);
        tick();
        bus.mem_busy = 1'b0;
        #1;
        chk("fi_drain3_ack", 32'(bus.req_ack), 32'd0);
        chk("fi_drain3_to", 32'(bus.drain_timeout), 32'd0);
        tick();
        chk("fi_ack", 32'(bus.req_ack), 32'd1);
        chk("fi_no_exc", 32'(bus.take_exc), 32'd0);
        chk("fi_no_mret", 32'(bus.mret_instr), 32'd0);
        chk("fi_cpc", bus.curr_pc, 32'hFFFF_FFFC);
        bus.fencei_req = 1'b0;
        tick();
        chk("fi_jvld", 32'(bus.jump_vld), 32'd1);
        chk("fi_wrap_jpc", bus.jump_pc, 32'h0000_0000);
        chk("fi_clear", 32'(bus.clear_pipeline), 32'd0);
        tick();

        // simultaneous exc, mret, irq
        bus.exc_req = 1'b1; bus.exc_code = 4'd11; bus.exc_pc = 32'h0000_2000;
        bus.mret_req = 1'b1; bus.irq_req = 1'b1; bus.int_pc = 32'h0000_3000;
        bus.csr_new_pc = 32'h0000_0100;
        tick();
        chk("pri_exc", 32'(bus.take_exc), 32'd1);
        chk("pri_no_mret", 32'(bus.mret_instr), 32'd0);
        chk("pri_no_irq", 32'(bus.take_irq), 32'd0);
        chk("pri_code", 32'(bus.exc_code_o), 32'd11);
        bus.exc_req = 1'b0;
        tick();
        chk("pri_jpc", bus.jump_pc, 32'h0000_0100);
        tick();
        chk("pri_idle_stall", 32'(bus.stall), 32'd1);
        chk("pri_idle_mret", 32'(bus.mret_instr), 32'd0);
        bus.csr_new_pc = 32'h0000_0400;
        tick();
        chk("mret_strobe", 32'(bus.mret_instr), 32'd1);
        chk("mret_ack", 32'(bus.req_ack), 32'd1);
        chk("mret_no_exc", 32'(bus.take_exc), 32'd0);
        chk("mret_no_irq", 32'(bus.take_irq), 32'd0);
        bus.mret_req = 1'b0;
        tick();
        chk("mret_jpc", bus.jump_pc, 32'h0000_0400);
        chk("mret_clear", 32'(bus.clear_pipeline), 32'd0);
        bus.irq_req = 1'b0;
        tick();
        chk("pri_done_stall", 32'(bus.stall), 32'd0);

        // drain timeout with memory stuck busy
`ifdef TRAP_SEQ_IRQ_EN
        bus.irq_req = 1'b1; bus.int_pc = 32'h0000_5000;
`else
        bus.exc_req = 1'b1; bus.exc_code = 4'd7; bus.exc_pc = 32'h0000_6000;
`endif
        bus.mem_busy = 1'b1;
        bus.csr_new_pc = 32'h0000_0700;
        for (int i = 1; i <= 14; i++) begin
            tick();
            chk("to_early", 32'(bus.drain_timeout), 32'd0);
        end
        tick();
        chk("to_pulse", 32'(bus.drain_timeout), 32'd1);
        chk("to_not_commit", 32'(bus.req_ack), 32'd0);
        tick();
        chk("to_after", 32'(bus.drain_timeout), 32'd0);
`ifdef TRAP_SEQ_IRQ_EN
        chk("to_take_irq", 32'(bus.take_irq), 32'd1);
        chk("to_irq_noack", 32'(bus.req_ack), 32'd0);
        chk("to_next_pc", bus.next_pc, 32'h0000_5000);
        bus.irq_req = 1'b0;
`else
        chk("to_take_exc", 32'(bus.take_exc), 32'd1);
        chk("to_exc_ack", 32'(bus.req_ack), 32'd1);
        chk("to_next_pc", bus.next_pc, 32'h0000_0000);
        chk("to_take_irq", 32'(bus.take_irq), 32'd0);
        bus.exc_req = 1'b0;
`endif
        bus.mem_busy = 1'b0;
        tick();
        chk("to_jpc", bus.jump_pc, 32'h0000_0700);
        chk("to_clear", 32'(bus.clear_pipeline), 32'd1);
        tick();

`ifdef TRAP_SEQ_IRQ_EN
        // interrupt withdrawn mid-drain
        bus.irq_req = 1'b1; bus.mem_busy = 1'b1;
        tick();
        chk("ab_drain_stall", 32'(bus.stall), 32'd1);
        tick();
        bus.irq_req = 1'b0;
        #1;
        chk("ab_no_irq", 32'(bus.take_irq), 32'd0);
        tick();
        chk("ab_idle_stall", 32'(bus.stall), 32'd0);
        chk("ab_no_ack", 32'(bus.req_ack), 32'd0);
        chk("ab_no_irq2", 32'(bus.take_irq), 32'd0);
        bus.mem_busy = 1'b0;
`else
        // interrupt request has no effect when interrupts are compiled out
        bus.irq_req = 1'b1; bus.int_pc = 32'h0000_5000;
        #1;
        chk("irqoff_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("irqoff_stall2", 32'(bus.stall), 32'd0);
        chk("irqoff_take", 32'(bus.take_irq), 32'd0);
        bus.irq_req = 1'b0;
`endif
        tick();

        // reset asserted during COMMIT
        bus.mret_req = 1'b1;
        tick();
        chk("rc_mret", 32'(bus.mret_instr), 32'd1);
        rst = 1'b0;
        #1;
        chk("rc_mret_low", 32'(bus.mret_instr), 32'd0);
        chk("rc_ack_low", 32'(bus.req_ack), 32'd0);
        chk("rc_stall", 32'(bus.stall), 32'd1);
        chk("rc_jvld", 32'(bus.jump_vld), 32'd0);
        bus.mret_req = 1'b0;
        tick();
        chk("rc_hold_jvld", 32'(bus.jump_vld), 32'd0);
        rst = 1'b1;
        tick();
        chk("rc_boot_jvld", 32'(bus.jump_vld), 32'd1);
        chk("rc_boot_jpc", bus.jump_pc, 32'h0000_0200);
        tick();
        chk("rc_idle_jvld", 32'(bus.jump_vld), 32'd0);
        chk("rc_idle_stall", 32'(bus.stall), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
